// File: rtl/uart_bus_bridge.sv
// UART byte-stream to 32-bit peripheral bus initiator.
// Frames: 'W' A3..A0 D3..D0 / 'R' A3..A0; reply is a status byte, plus 4 data bytes on a good read.
`timescale 1ns/1ps
module uart_bus_bridge #(
  parameter int unsigned BUS_TIMEOUT     = 1024,
  parameter int unsigned RX_IDLE_TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        mem_valid_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o
);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] ST_OK     = 8'h4B;
  localparam logic [7:0] ST_ERR    = 8'h45;
  localparam int WW = $clog2(BUS_TIMEOUT + 1);
  localparam int IW = $clog2(RX_IDLE_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(BUS_TIMEOUT - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(RX_IDLE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    GET_ADDR    = 3'd1,
    GET_DATA    = 3'd2,
    BUS_REQ     = 3'd3,
    SEND_STATUS = 3'd4,
    SEND_DATA   = 3'd5
  } state_t;

  state_t        state;
  logic          is_write;
  logic          rd_ok;
  logic [1:0]    byte_cnt;
  logic [WW-1:0] wait_cnt;
  logic [IW-1:0] idle_cnt;
  logic [31:0]   rdata;
  logic          rx_fire;
  logic          tx_fire;

  assign rx_fire = rx_valid_i && rx_ready_o;
  assign tx_fire = tx_valid_o && tx_ready_i;

  // Command FSM; every UART and bus output is registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      is_write    <= 1'b0;
      rd_ok       <= 1'b0;
      byte_cnt    <= 2'd0;
      wait_cnt    <= '0;
      idle_cnt    <= '0;
      rdata       <= 32'h0;
      rx_ready_o  <= 1'b1;
      tx_data_o   <= 8'h00;
      tx_valid_o  <= 1'b0;
      mem_valid_o <= 1'b0;
      mem_addr_o  <= 32'h0;
      mem_wdata_o <= 32'h0;
      mem_wstrb_o <= 4'h0;
      busy_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_fire && (rx_data_i == CMD_WRITE || rx_data_i == CMD_READ)) begin
            is_write <= (rx_data_i == CMD_WRITE);
            byte_cnt <= 2'd0;
            idle_cnt <= '0;
            busy_o   <= 1'b1;
            state    <= GET_ADDR;
          end
        end
        GET_ADDR, GET_DATA: begin
          if (rx_fire) begin
            idle_cnt <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            if (state == GET_ADDR) begin
              mem_addr_o <= {mem_addr_o[23:0], rx_data_i};
            end else begin
              mem_wdata_o <= {mem_wdata_o[23:0], rx_data_i};
            end
            if (byte_cnt == 2'd3) begin
              if (state == GET_ADDR && is_write) begin
                state <= GET_DATA;
              end else begin
                rx_ready_o <= 1'b0;
                wait_cnt   <= '0;
                state      <= BUS_REQ;
              end
            end
          end else if (idle_cnt == IDLE_LAST) begin
            // Stalled partial frame: drop it silently and resync on the next command byte.
            idle_cnt <= '0;
            busy_o   <= 1'b0;
            state    <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end
        BUS_REQ: begin
          if (!mem_valid_o) begin
            mem_valid_o <= 1'b1;
            mem_wstrb_o <= is_write ? 4'hF : 4'h0;
          end else if (mem_ready_i) begin
            rdata       <= mem_rdata_i;
            rd_ok       <= !is_write;
            mem_valid_o <= 1'b0;
            mem_wstrb_o <= 4'h0;
            tx_data_o   <= ST_OK;
            tx_valid_o  <= 1'b1;
            state       <= SEND_STATUS;
          end else if (wait_cnt == WAIT_LAST) begin
            rd_ok       <= 1'b0;
            mem_valid_o <= 1'b0;
            mem_wstrb_o <= 4'h0;
            tx_data_o   <= ST_ERR;
            tx_valid_o  <= 1'b1;
            state       <= SEND_STATUS;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        SEND_STATUS: begin
          if (tx_fire) begin
            if (rd_ok) begin
              tx_data_o <= rdata[31:24];
              rdata     <= {rdata[23:0], 8'h00};
              byte_cnt  <= 2'd0;
              state     <= SEND_DATA;
            end else begin
              tx_valid_o <= 1'b0;
              tx_data_o  <= 8'h00;
              rx_ready_o <= 1'b1;
              busy_o     <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        SEND_DATA: begin
          if (tx_fire) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              tx_valid_o <= 1'b0;
              tx_data_o  <= 8'h00;
              rx_ready_o <= 1'b1;
              busy_o     <= 1'b0;
              state      <= IDLE;
            end else begin
              tx_data_o <= rdata[31:24];
              rdata     <= {rdata[23:0], 8'h00};
            end
          end
        end
        default: begin
          tx_valid_o  <= 1'b0;
          mem_valid_o <= 1'b0;
          mem_wstrb_o <= 4'h0;
          rx_ready_o  <= 1'b1;
          busy_o      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Scoreboard bench for uart_bus_bridge: expected bus transactions and TX bytes are queued
// as frames are sent, then checked by a bus responder and a TX sink as the DUT produces them.
`timescale 1ns/1ps
module tb_uart_bus_bridge;

  localparam int BT = 16;
  localparam int RT = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        mem_valid_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o;

  always #5 clk = ~clk;

  uart_bus_bridge #(.BUS_TIMEOUT(BT), .RX_IDLE_TIMEOUT(RT)) dut (
    .clk(clk), .reset(reset),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wstrb_o(mem_wstrb_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        chk_wdata;
    int          delay;   // cycles after valid before ready; 0 = never answer
    logic [31:0] rdata;
    int          len;     // expected number of cycles mem_valid_o stays high
  } txn_t;

  txn_t       exp_txn[$];
  logic [7:0] exp_tx[$];
  int n_vec = 0;
  int n_err = 0;
  int bus_viol = 0;
  int tx_viol = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bus responder: checks each transaction against the scoreboard and answers it.
  initial begin : responder
    txn_t t;
    int   k;
    bit   ready_on;
    mem_ready_i = 1'b0;
    mem_rdata_i = 32'h0;
    forever begin
      @(negedge clk);
      if (!mem_valid_o) begin
        if (mem_wstrb_o !== 4'h0) bus_viol++;
      end else begin
        if (exp_txn.size() > 0) begin
          t = exp_txn.pop_front();
        end else begin
          t.addr = 'x; t.wdata = 'x; t.wstrb = 'x; t.chk_wdata = 1'b0;
          t.delay = 1; t.rdata = 32'h0; t.len = 2;
        end
        check("txn_addr", mem_addr_o, t.addr);
        check("txn_wstrb", 32'(mem_wstrb_o), 32'(t.wstrb));
        if (t.chk_wdata) check("txn_wdata", mem_wdata_o, t.wdata);
        k = 0;
        ready_on = 1'b0;
        while (mem_valid_o && k < 200) begin
          k++;
          if (mem_addr_o !== t.addr || mem_wstrb_o !== t.wstrb ||
              (t.chk_wdata && mem_wdata_o !== t.wdata)) bus_viol++;
          if (ready_on) begin
            @(posedge clk); #1;
            mem_ready_i = 1'b0;
            mem_rdata_i = 32'h0;
            ready_on = 1'b0;
            check("tx_latency", 32'(tx_valid_o), 32'd1);
            check("tx_status_ok", 32'(tx_data_o), 32'h4B);
          end else if (k == t.delay) begin
            @(posedge clk); #1;
            mem_ready_i = 1'b1;
            mem_rdata_i = t.rdata;
            ready_on = 1'b1;
          end
          @(negedge clk);
        end
        check("valid_len", 32'(k), 32'(t.len));
      end
    end
  end

  // TX sink: pops expected bytes on each handshake and watches for unstable held bytes.
  initial begin : tx_sink
    logic [7:0] e;
    bit         pend;
    logic [7:0] pdata;
    pend = 1'b0;
    pdata = 8'h00;
    forever begin
      @(negedge clk);
      if (pend && (!tx_valid_o || tx_data_o !== pdata)) tx_viol++;
      if (tx_valid_o && tx_ready_i) begin
        if (exp_tx.size() > 0) e = exp_tx.pop_front();
        else e = 8'hxx;
        check("tx_byte", 32'(tx_data_o), 32'(e));
      end
      pend = tx_valid_o && !tx_ready_i;
      pdata = tx_data_o;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(posedge clk); #1;
    rx_data_i = b;
    rx_valid_i = 1'b1;
    @(negedge clk);
    while (!rx_ready_o && n < 2000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 2000) check("rx_accept", 32'(rx_ready_o), 32'd1);
    @(posedge clk); #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic push_txn(input logic [31:0] a, input logic [31:0] d, input logic wr,
                          input int dly, input logic [31:0] rd, input int len);
    txn_t t;
    t.addr = a; t.wdata = d; t.wstrb = wr ? 4'hF : 4'h0; t.chk_wdata = wr;
    t.delay = dly; t.rdata = rd;
    t.len = (len > 0) ? len : ((dly > 0) ? dly + 1 : BT);
    exp_txn.push_back(t);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int dly);
    push_txn(a, d, 1'b1, dly, 32'h0, 0);
    exp_tx.push_back((dly > 0) ? 8'h4B : 8'h45);
    send_byte(8'h57);
    for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
    for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] rd, input int dly,
                         input bit resp, input int len);
    push_txn(a, 32'h0, 1'b0, dly, rd, len);
    if (resp) begin
      if (dly > 0) begin
        exp_tx.push_back(8'h4B);
        for (int i = 3; i >= 0; i--) exp_tx.push_back(rd[8*i +: 8]);
      end else begin
        exp_tx.push_back(8'h45);
      end
    end
    send_byte(8'h52);
    for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy_o || exp_tx.size() != 0 || exp_txn.size() != 0) && n < 3000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 3000)
      check("idle_wait", 32'(busy_o) | 32'(exp_tx.size()) | 32'(exp_txn.size()), 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    logic [31:0] ra, rd;
    reset = 1'b1;
    rx_data_i = 8'h00;
    rx_valid_i = 1'b0;
    tx_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rx_ready", 32'(rx_ready_o), 32'd1);
    check("rst_tx_valid", 32'(tx_valid_o), 32'd0);
    check("rst_tx_data", 32'(tx_data_o), 32'd0);
    check("rst_mem_valid", 32'(mem_valid_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_mem_wdata", mem_wdata_o, 32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Write with ready 3 cycles after valid, plus RX-to-bus latency.
    do_write(32'h0000_0000, 32'h0000_01F4, 3);
    @(negedge clk);
    check("lat_valid_low", 32'(mem_valid_o), 32'd0);
    check("busy_in_req", 32'(busy_o), 32'd1);
    @(negedge clk);
    check("lat_valid_high", 32'(mem_valid_o), 32'd1);
    wait_idle();

    do_read(32'h0000_0008, 32'h0000_0001, 2, 1'b1, 0);
    wait_idle();

    // No responder: bus timeout, then a normal command.
    do_read(32'hDEAD_0000, 32'h0, 0, 1'b1, 0);
    wait_idle();
    do_read(32'h0000_0004, 32'hA5A5_5A5A, 1, 1'b1, 0);
    wait_idle();

    // Junk bytes are dropped silently.
    send_byte(8'hFF);
    send_byte(8'h00);
    @(negedge clk);
    check("junk_busy", 32'(busy_o), 32'd0);
    do_read(32'h0000_0010, 32'h1234_5678, 4, 1'b1, 0);
    wait_idle();

    // Partial frame abandoned by the RX idle timeout.
    send_byte(8'h52);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (45) @(negedge clk);
    check("partial_busy", 32'(busy_o), 32'd1);
    repeat (10) @(negedge clk);
    check("partial_dropped", 32'(busy_o), 32'd0);
    do_read(32'h0000_0020, 32'hCAFE_F00D, 2, 1'b1, 0);
    wait_idle();

    // TX backpressure in the middle of read data.
    do_read(32'h0000_0030, 32'h0102_0304, 2, 1'b1, 0);
    n = 0;
    @(posedge clk); #1;
    while (exp_tx.size() > 3 && n < 500) begin
      n++;
      @(posedge clk); #1;
    end
    if (n >= 500) check("stall_wait", 32'(exp_tx.size()), 32'd3);
    tx_ready_i = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("stall_valid", 32'(tx_valid_o), 32'd1);
    check("stall_data", 32'(tx_data_o), 32'h02);
    tx_ready_i = 1'b1;
    wait_idle();

    // Back-to-back commands.
    do_write(32'h0000_0040, 32'h55AA_55AA, 1);
    do_read(32'h0000_0040, 32'h55AA_55AA, 2, 1'b1, 0);
    wait_idle();

    for (int i = 0; i < 4; i++) begin
      ra = $urandom & 32'hFFFF_FFFC;
      rd = $urandom;
      if (i % 2 == 0) do_write(ra, rd, $urandom_range(1, 6));
      else do_read(ra, rd, $urandom_range(1, 6), 1'b1, 0);
    end
    wait_idle();

    // Asynchronous reset while the bus request is outstanding.
    do_read(32'h0000_0050, 32'h0, 0, 1'b0, 3);
    repeat (4) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_mem_valid", 32'(mem_valid_o), 32'd0);
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_rx_ready", 32'(rx_ready_o), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    do_read(32'h0000_0060, 32'h8765_4321, 3, 1'b1, 0);
    wait_idle();

    repeat (3) @(negedge clk);
    check("bus_hold", 32'(bus_viol), 32'd0);
    check("tx_hold", 32'(tx_viol), 32'd0);
    check("txn_left", 32'(exp_txn.size()), 32'd0);
    check("tx_left", 32'(exp_tx.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_bus_bridge.md
Name: uart_bus_bridge

Overview:
- Byte-stream-to-memory-bus initiator for bench and debug access to the on-chip peripheral bus (OCD control, timers) without the CPU.
- Sits between the UART RX/TX byte interfaces and the peripheral bus; acts as the bus initiator toward the responders.
- Decodes framed read/write commands, issues one 32-bit bus transaction per command and returns a status/data response.

Parameters:
- BUS_TIMEOUT, 1024: cycles to wait for mem_ready_i before aborting the transaction.
- RX_IDLE_TIMEOUT, 100000: cycles without an RX byte inside a partial frame before the frame is discarded.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rx_data_i  input  8  received byte
- rx_valid_i  input  1  rx_data_i valid
- rx_ready_o  output  1  bridge accepts a byte; transfer when rx_valid_i && rx_ready_o
- tx_data_o  output  8  response byte
- tx_valid_o  output  1  tx_data_o valid
- tx_ready_i  input  1  transmitter accepts; transfer when tx_valid_o && tx_ready_i
- mem_valid_o  output  1  bus request
- mem_addr_o  output  32  bus address
- mem_wdata_o  output  32  write data
- mem_wstrb_o  output  4  byte strobes; 4'hF on write, 4'h0 on read
- mem_ready_i  input  1  responder completion, one-cycle pulse
- mem_rdata_i  input  32  read data, valid while mem_ready_i is high
- busy_o  output  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous): state IDLE; rx_ready_o=1; tx_valid_o=0; tx_data_o=0; mem_valid_o=0; mem_addr_o=0; mem_wdata_o=0; mem_wstrb_o=0; busy_o=0; all counters cleared.
- Frame format:
  - Write: 0x57, A3 A2 A1 A0, D3 D2 D1 D0 (big-endian).
  - Read: 0x52, A3 A2 A1 A0.
- Response format:
  - Status byte first: 0x4B OK, 0x45 bus timeout.
  - Successful read: status followed by 4 data bytes, MSB first.
  - Write, or read with error: status byte only.
- States:
  - IDLE: rx_ready_o=1. Byte 0x57 or 0x52 latches the command and goes to GET_ADDR. Any other byte is dropped silently and the state stays IDLE (resync).
  - GET_ADDR: shift in 4 bytes into mem_addr_o (MSB first). After the 4th byte: write goes to GET_DATA, read goes to BUS_REQ.
  - GET_DATA: shift in 4 bytes into mem_wdata_o, then go to BUS_REQ.
  - BUS_REQ: rx_ready_o=0. mem_valid_o=1 starting the cycle after entry, with mem_wstrb_o set per command. mem_addr_o, mem_wdata_o and mem_wstrb_o stay stable while mem_valid_o=1.
    - On the cycle mem_ready_i=1: capture mem_rdata_i, set status 0x4B, deassert mem_valid_o on the next edge, go to SEND_STATUS.
    - If mem_ready_i is never seen and the wait counter reaches BUS_TIMEOUT: deassert mem_valid_o, set status 0x45, go to SEND_STATUS.
  - SEND_STATUS: tx_valid_o=1 with the status byte, held stable until tx_ready_i. Then a successful read goes to SEND_DATA; everything else goes to IDLE.
  - SEND_DATA: send captured bytes [31:24], [23:16], [15:8], [7:0], each held until accepted, then go to IDLE.
- Bus spacing: mem_valid_o is low for at least 1 cycle between consecutive transactions. This is guaranteed structurally, since at least 1 TX byte sits between transactions. Responders detect a new transaction on a rising mem_valid.
- mem_ready_i outside BUS_REQ is ignored. mem_wstrb_o returns to 0 whenever mem_valid_o=0.
- RX idle timeout:
  - The idle counter runs in GET_ADDR and GET_DATA and resets on each accepted byte.
  - When it reaches RX_IDLE_TIMEOUT, the partial frame is discarded, the state returns to IDLE, and no response is sent.
- A byte arriving while rx_ready_o=0 is not consumed. Backpressure is left to the upstream FIFO.
- busy_o = (state != IDLE), registered.
- Latency: last RX byte accepted → mem_valid_o high in 2 cycles. mem_ready_i pulse → tx_valid_o high in 1 cycle.
- Reset mid-transaction: all outputs drop immediately and the frame is lost. The responder sees mem_valid fall with no ready, which is legal.

Test Plan:
- Write 0x57,00,00,00,00,00,00,01,F4; responder pulses ready 3 cycles after valid → one transaction with addr=0x00000000, wdata=0x000001F4, wstrb=4'hF; TX 0x4B; mem_valid_o high for exactly 4 cycles.
- Read 0x52,00,00,00,08; responder returns rdata=0x00000001 → wstrb=0; TX 0x4B,00,00,00,01.
- Read to an address with no responder, BUS_TIMEOUT=16 → mem_valid_o drops after 16 cycles; TX 0x45 only; next command is accepted normally.
- Junk bytes 0xFF,0x00 followed by a valid read → junk dropped, no TX; the read completes.
- Send 0x52,00,00 then stall > RX_IDLE_TIMEOUT (set to 50), then a full read → first frame discarded with no TX; second read responds correctly.
- Hold tx_ready_i low for 20 cycles during SEND_DATA → tx_data_o stable, no byte lost or duplicated; back-to-back commands give mem_valid_o a gap of at least 1 cycle; async reset asserted in BUS_REQ clears mem_valid_o without waiting for a clock edge.
